// File: rtl/gb_intctl.sv
// gb_intctl: DMG interrupt controller with IF/IE registers, source edge detection and the ack/vector handshake.
// Optional macro GB_INTCTL_WAKE_EN adds a registered wake output (|pending) for HALT/STOP exit.
`default_nettype none

module gb_intctl #(
  parameter int          NSRC     = 5,
  parameter logic [7:0]  VEC_BASE = 8'h40
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sel_if,
  input  logic            sel_ie,
  input  logic            wr,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  input  logic [NSRC-1:0] src,
  input  logic            ime,
  output logic            irq,
  input  logic            int_ack,
  output logic [7:0]      int_vec
`ifdef GB_INTCTL_WAKE_EN
  ,
  output logic            wake
`endif
);

  localparam int IW = $clog2(NSRC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [NSRC-1:0] if_q, if_d;
  logic [7:0]      ie_q, ie_d;
  logic [NSRC-1:0] src_prev_q;
  logic [0:0]      state_q, state_d;
  logic [7:0]      vec_q, vec_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending;
  logic            any_pend;
  logic [IW-1:0]   win_idx;
  logic            capture;

  assign rise     = src & ~src_prev_q;
  assign pending  = if_q & ie_q[NSRC-1:0];
  assign any_pend = |pending;
  assign capture  = (state_q == ST_IDLE) && int_ack;

  // Scan from the top so the lowest set bit is left in win_idx.
  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = i[IW-1:0];
    end
  end

  // Per-bit precedence: source rise over ack clear over CPU write.
  always_comb begin
    if_d = if_q;
    if (wr && sel_if) if_d = data_in[NSRC-1:0];
    if (capture && any_pend) if_d[win_idx] = 1'b0;
    if_d = if_d | rise;
  end

  always_comb begin
    ie_d = ie_q;
    if (wr && sel_ie) ie_d = data_in;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (int_ack) begin
          state_d = ST_ACK;
          vec_d   = any_pend ? (VEC_BASE + 8'({win_idx, 3'b000})) : 8'h00;
        end
      end
      default: begin
        if (!int_ack) begin
          state_d = ST_IDLE;
          vec_d   = 8'h00;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_q       <= '0;
      ie_q       <= 8'h00;
      src_prev_q <= '1;
      state_q    <= ST_IDLE;
      vec_q      <= 8'h00;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      src_prev_q <= src;
      state_q    <= state_d;
      vec_q      <= vec_d;
    end
  end

  always_comb begin
    data_out = 8'hff;
    if (sel_if)      data_out = {{(8-NSRC){1'b1}}, if_q};
    else if (sel_ie) data_out = ie_q;
  end

  assign irq     = ime && any_pend && (state_q == ST_IDLE);
  assign int_vec = vec_q;

`ifdef GB_INTCTL_WAKE_EN
  logic wake_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wake_q <= 1'b0;
    else          wake_q <= any_pend;
  end

  assign wake = wake_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gb_intctl.sv
// Self-checking bench for gb_intctl: spec-level model compared every cycle plus directed literal checks.
`default_nettype none

module tb_gb_intctl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sel_if = 1'b0, sel_ie = 1'b0, wr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [4:0] src = 5'b00001;
  logic       ime = 1'b0, int_ack = 1'b0;
  wire  [7:0] data_out, int_vec;
  wire        irq;
`ifdef GB_INTCTL_WAKE_EN
  wire        wake;
`endif

  int passed = 0;
  int total  = 0;
  bit run    = 1'b0;

  gb_intctl dut (
    .clk(clk), .reset_n(reset_n), .sel_if(sel_if), .sel_ie(sel_ie), .wr(wr),
    .data_in(data_in), .data_out(data_out), .src(src), .ime(ime), .irq(irq),
    .int_ack(int_ack), .int_vec(int_vec)
`ifdef GB_INTCTL_WAKE_EN
    , .wake(wake)
`endif
  );

  always #5 clk = ~clk;

  // Spec-level model state
  logic [4:0] m_if = 5'h00, m_prev = 5'h1f;
  logic [7:0] m_ie = 8'h00, m_vec = 8'h00;
  bit         m_in_ack = 1'b0, m_wake = 1'b0;

  logic [4:0] t_rise, t_pend, t_low, t_nif;
  int         t_w;
  bit         t_dispatch;

  always_comb begin
    t_rise     = src & ~m_prev;
    t_pend     = m_if & m_ie[4:0];
    t_low      = t_pend & (~t_pend + 5'd1);
    t_w        = (t_low == 5'd0) ? 0 : $clog2(t_low);
    t_dispatch = !m_in_ack && int_ack && (t_pend != 5'd0);
    t_nif      = m_if;
    for (int n = 0; n < 5; n++) begin
      if (t_rise[n])                     t_nif[n] = 1'b1;
      else if (t_dispatch && n == t_w)   t_nif[n] = 1'b0;
      else if (wr && sel_if)             t_nif[n] = data_in[n];
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_if <= 5'h00; m_ie <= 8'h00; m_prev <= 5'h1f;
      m_vec <= 8'h00; m_in_ack <= 1'b0; m_wake <= 1'b0;
    end else begin
      m_if   <= t_nif;
      m_prev <= src;
      m_wake <= (t_pend != 5'd0);
      if (wr && sel_ie) m_ie <= data_in;
      if (!m_in_ack && int_ack) begin
        m_in_ack <= 1'b1;
        m_vec    <= (t_pend != 5'd0) ? 8'(8'h40 + 8 * t_w) : 8'h00;
      end else if (m_in_ack && !int_ack) begin
        m_in_ack <= 1'b0;
        m_vec    <= 8'h00;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("irq", {7'd0, irq}, {7'd0, ime && (t_pend != 5'd0) && !m_in_ack});
      check("int_vec", int_vec, m_vec);
      check("data_out", data_out,
            sel_if ? {3'b111, m_if} : (sel_ie ? m_ie : 8'hff));
`ifdef GB_INTCTL_WAKE_EN
      check("wake", {7'd0, wake}, {7'd0, m_wake});
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wreg(input bit is_if, input logic [7:0] d);
    sel_if = is_if; sel_ie = !is_if; wr = 1'b1; data_in = d;
    step();
    wr = 1'b0; sel_if = 1'b0; sel_ie = 1'b0;
  endtask

  task automatic pulse(input int n);
    src = 5'(1 << n);
    step();
    src = 5'd0;
    step();
  endtask

  task automatic chk_neg(input string name, input logic [7:0] act_sel, input logic [7:0] exp);
    @(negedge clk);
    case (act_sel)
      8'd0:    check(name, data_out, exp);
      8'd1:    check(name, int_vec, exp);
      default: check(name, {7'd0, irq}, exp);
    endcase
  endtask

  initial begin
    #2 reset_n = 1'b0;
    run = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step(); step();

    // Source already high at release must not set IF
    sel_if = 1'b1;
    chk_neg("rst_if_read", 8'd0, 8'he0);
    chk_neg("rst_irq", 8'd2, 8'h00);
    src = 5'd0; step();
    src = 5'd1; step();
    chk_neg("rise0_if_read", 8'd0, 8'he1);
    sel_if = 1'b0;
    wreg(1'b1, 8'h00);

    // Priority dispatch: src[2] then src[0], vblank wins first
    wreg(1'b0, 8'h05);
    ime = 1'b1;
    pulse(2);
    pulse(0);
    chk_neg("two_pend_irq", 8'd2, 8'h01);
    int_ack = 1'b1; step();
    sel_if = 1'b1;
    chk_neg("ack1_vec", 8'd1, 8'h40);
    chk_neg("ack1_if", 8'd0, 8'he4);
    int_ack = 1'b0; step();
    chk_neg("rel1_irq", 8'd2, 8'h01);
    int_ack = 1'b1; step();
    chk_neg("ack2_vec", 8'd1, 8'h50);
    chk_neg("ack2_if", 8'd0, 8'he0);
    int_ack = 1'b0; step();
    chk_neg("rel2_irq", 8'd2, 8'h00);
    sel_if = 1'b0;

    // ime gating is combinational
    wreg(1'b0, 8'h1f);
    ime = 1'b0;
    pulse(4);
    sel_if = 1'b1;
    chk_neg("joy_if", 8'd0, 8'hf0);
    chk_neg("joy_irq_noime", 8'd2, 8'h00);
    sel_if = 1'b0;
    ime = 1'b1;
    chk_neg("joy_irq_ime", 8'd2, 8'h01);
    int_ack = 1'b1; step();
    chk_neg("joy_vec", 8'd1, 8'h60);
    ime = 1'b0; step();
    chk_neg("ack_hold_vec", 8'd1, 8'h60);
    int_ack = 1'b0; ime = 1'b1; step();

    // Cancelled dispatch
    wreg(1'b0, 8'h02);
    wreg(1'b1, 8'h02);
    wreg(1'b1, 8'h00);
    int_ack = 1'b1; step();
    sel_if = 1'b1;
    chk_neg("cancel_vec", 8'd1, 8'h00);
    chk_neg("cancel_if", 8'd0, 8'he0);
    sel_if = 1'b0;
    int_ack = 1'b0; step();

    // Rise beats ack clear beats CPU write
    wreg(1'b1, 8'h02);
    int_ack = 1'b1; src = 5'b00010;
    sel_if = 1'b1; wr = 1'b1; data_in = 8'h00;
    step();
    wr = 1'b0;
    chk_neg("conflict_if", 8'd0, 8'he2);
    chk_neg("conflict_vec", 8'd1, 8'h48);
    sel_if = 1'b0; int_ack = 1'b0; src = 5'd0;
    step();
    wreg(1'b1, 8'h00);

    // IE write concurrent with capture uses old IE
    wreg(1'b0, 8'h01);
    wreg(1'b1, 8'h01);
    int_ack = 1'b1; sel_ie = 1'b1; wr = 1'b1; data_in = 8'h00;
    step();
    wr = 1'b0; sel_ie = 1'b0;
    chk_neg("ie_race_vec", 8'd1, 8'h40);
    int_ack = 1'b0; step();

`ifdef GB_INTCTL_WAKE_EN
    ime = 1'b0;
    wreg(1'b0, 8'h08);
    src = 5'b01000; step(); src = 5'd0;
    @(negedge clk); check("wake_lag", {7'd0, wake}, 8'h00);
    step();
    @(negedge clk); check("wake_set", {7'd0, wake}, 8'h01);
    wreg(1'b1, 8'h00);
    @(negedge clk); check("wake_hold", {7'd0, wake}, 8'h01);
    step();
    @(negedge clk); check("wake_clr", {7'd0, wake}, 8'h00);
    ime = 1'b1;
`endif

    // Async reset in the middle of ACK
    wreg(1'b0, 8'h01);
    pulse(0);
    int_ack = 1'b1; step();
    chk_neg("pre_rst_vec", 8'd1, 8'h40);
    step();
    reset_n = 1'b0;
    #1;
    check("rst_ack_vec", int_vec, 8'h00);
    check("rst_ack_irq", {7'd0, irq}, 8'h00);
`ifdef GB_INTCTL_WAKE_EN
    check("rst_ack_wake", {7'd0, wake}, 8'h00);
`endif
    int_ack = 1'b0;
    step();
    reset_n = 1'b1;
    step(); step();

    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/gb_intctl.md
Name: gb_intctl

Overview:
- Interrupt controller for the SoC.
- Holds the IF (0xff0f) and IE (0xffff) registers and edge-detects the five peripheral interrupt sources.
- Raises irq to the CPU and runs the acknowledge/vector handshake.
- Sits behind the I/O address decoder: consumes its sel_if/sel_ie strobes and returns read data to the CPU data mux.

Parameters:
- NSRC, 5, number of interrupt sources; fixed at 5 for DMG, bits above NSRC-1 in IF read as 1.
- VEC_BASE, 8'h40, vector of source 0; source n vector = VEC_BASE + 8*n.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel_if  in  1  decoder strobe for 0xff0f.
- sel_ie  in  1  decoder strobe for 0xffff.
- wr  in  1  CPU write strobe, qualified by sel_*.
- data_in  in  8  CPU write data.
- data_out  out  8  read data; combinational from registers.
- src  in  5  level requests: [0] vblank, [1] stat, [2] timer, [3] serial, [4] joypad.
- ime  in  1  CPU master interrupt enable.
- irq  out  1  interrupt request to CPU.
- int_ack  in  1  CPU acknowledge, held high until int_vec consumed.
- int_vec  out  8  dispatch vector, valid in ACK state.

Behaviour:
- Reset (async, reset_n=0):
  - IF=5'h00, IE=8'h00, src_prev=5'h1f (suppresses edges of sources already high at release).
  - state=IDLE, int_vec=8'h00, irq=0.
- Edge detect: rise[n] = src[n] & ~src_prev[n]. src_prev <= src every cycle. A rise in cycle k sets IF[n] at edge k; irq can assert in cycle k+1.
- Register writes:
  - wr & sel_if: IF <= data_in[4:0].
  - wr & sel_ie: IE <= data_in.
- Register reads:
  - sel_if: data_out = {3'b111, IF}.
  - sel_ie: data_out = IE.
  - Neither selected: data_out = 8'hff.
- pending = IF & IE[4:0]. irq = ime & |pending & (state==IDLE). Registered inputs only, no combinational path from src.
- Priority: lowest set bit of pending wins (vblank highest).
- State machine, two states:
  - IDLE: int_ack=1 sampled moves to ACK. On that edge, the winning index w is captured, int_vec <= VEC_BASE + 8*w, and IF[w] is cleared. If pending==0 at that edge (cancelled dispatch), int_vec <= 8'h00 and IF is unchanged.
  - ACK: int_vec held stable. irq=0. int_ack=0 returns to IDLE, and int_vec <= 8'h00 on that edge.
- Same-cycle conflicts, per bit, in descending precedence:
  1. source rise sets the bit;
  2. ack clear;
  3. CPU write.
  A rise on the bit being acked therefore leaves the bit set.
- Write to IE in the same cycle as the ack capture: the capture uses the pre-write IE.
- ime is ignored in ACK. ime falling during ACK has no effect on the handshake.
- reset_n asserted mid-ACK: immediate return to IDLE with the reset values above.

Optional Feature:
- Macro: GB_INTCTL_WAKE_EN.
- Defined:
  - Adds output wake (1 bit) = |pending, regardless of ime and state, for HALT/STOP exit.
  - wake is registered: it asserts one cycle after pending becomes non-zero and resets to 0.
- Undefined: no wake port; HALT exit logic lives in the CPU.

Test Plan:
- Reset release with src=5'b00001 held high: IF stays 0x00 (reads 0xe0), irq=0. Dropping src[0] then raising it sets IF=0x01 (reads 0xe1).
- IE=0x05, ime=1, pulse src[2] then src[0]: irq=1. First ack gives int_vec=0x40 and IF=0x04. Release ack, irq=1 again. Second ack gives int_vec=0x50 and IF=0x00; irq drops.
- IE=0x1f, ime=0, pulse src[4]: IF=0x10, irq=0. Set ime=1: irq=1 the same cycle. Ack gives int_vec=0x60.
- IF=0x02, IE=0x02. CPU writes IF=0x00 in the cycle before ack, then ack → int_vec=0x00 (cancelled dispatch), IF stays 0x00.
- Ack capture of bit 1 in the same cycle as a src[1] rise and a CPU write of IF=0x00: after the edge IF=0x02, int_vec=0x48.
- With GB_INTCTL_WAKE_EN: ime=0, IE=0x08, pulse src[3] → wake=1 one cycle after IF[3] sets. Write IF=0x00 → wake=0 next cycle. Assert reset_n=0 in ACK → int_vec=0x00, irq=0, wake=0 immediately.
